// File: rtl/apb_bus_master.sv
// apb_bus_master: single-initiator APB bridge to GPIO (slave 0) and UART (slave 1) with wait-state timeout
module apb_bus_master #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [1:0] PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [1:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA0,
  input  logic [7:0] PRDATA1,
  input  logic       PREADY0,
  input  logic       PREADY1
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;
  logic idx, sel_ready, timeout, done, accept;
  logic [7:0] sel_data;
  logic [CW-1:0] cnt;
  always_comb begin
    sel_ready = idx ? PREADY1 : PREADY0;
    sel_data = idx ? PRDATA1 : PRDATA0;
    req_ready = rst_n && state == IDLE;
    accept = req_valid && req_ready;
    // abort on the edge that ends the TIMEOUT-th PREADY-low ACCESS cycle
    timeout = TIMEOUT != 0 && !sel_ready && cnt + CW'(1) == TO;
    done = state == ACCESS && (sel_ready || timeout);
    PSEL = state == IDLE ? 2'b00 : {idx, !idx};
    PENABLE = state == ACCESS;
    state_nxt = state == IDLE ? (accept ? SETUP : IDLE) :
                state == SETUP ? ACCESS : (done ? IDLE : ACCESS);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 1'b0;
      cnt <= '0;
      PWRITE <= 1'b0;
      PADDR <= 2'b00;
      PWDATA <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      rsp_valid <= done;
      if (accept) begin
        idx <= req_addr[2];
        PWRITE <= req_write;
        PADDR <= req_addr[1:0];
        PWDATA <= req_wdata;
        cnt <= '0;
      end else if (state == ACCESS && !sel_ready) begin
        cnt <= cnt + CW'(1);
      end
      if (done) begin
        rsp_rdata <= (sel_ready && !PWRITE) ? sel_data : 8'h00;
        rsp_err <= !sel_ready;
      end
    end
  end
endmodule

// File: tb/tb_apb_bus_master.sv
// tb_apb_bus_master: directed stimulus with a response scoreboard checked by a separate monitor
module tb_apb_bus_master;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [2:0] req_addr = 3'b000;
  logic [7:0] req_wdata = 8'h00, PRDATA0 = 8'h00, PRDATA1 = 8'h00;
  logic PREADY0 = 1'b0, PREADY1 = 1'b0;
  logic req_ready, rsp_valid, rsp_err, PENABLE, PWRITE;
  logic [7:0] rsp_rdata, PWDATA;
  logic [1:0] PSEL, PADDR;
  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  apb_bus_master #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PREADY0(PREADY0), .PREADY1(PREADY1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[8:1]});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
      end
    end
  end
  task automatic chk_reset_vals(input string n);
    chk({n, "_psel"}, {30'd0, PSEL}, 32'd0);
    chk({n, "_penable"}, {31'd0, PENABLE}, 32'd0);
    chk({n, "_pwrite"}, {31'd0, PWRITE}, 32'd0);
    chk({n, "_paddr"}, {30'd0, PADDR}, 32'd0);
    chk({n, "_pwdata"}, {24'd0, PWDATA}, 32'd0);
    chk({n, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({n, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    chk({n, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({n, "_req_ready"}, {31'd0, req_ready}, 32'd0);
  endtask
  task automatic issue(input logic w, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  initial begin
    int acc, cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    // zero-wait GPIO write
    PREADY0 = 1'b1;
    exp_q.push_back({8'h00, 1'b0});
    issue(1'b1, 3'b010, 8'hA5);
    @(negedge clk);
    chk("wr_setup_psel", {30'd0, PSEL}, 32'd1);
    chk("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("wr_setup_pwrite", {31'd0, PWRITE}, 32'd1);
    chk("wr_setup_paddr", {30'd0, PADDR}, 32'd2);
    chk("wr_setup_pwdata", {24'd0, PWDATA}, 32'hA5);
    @(negedge clk);
    chk("wr_access_penable", {31'd0, PENABLE}, 32'd1);
    @(negedge clk);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    // UART read with three wait states; GPIO inputs must be ignored
    PRDATA0 = 8'hFF;
    PREADY1 = 1'b0;
    exp_q.push_back({8'h3C, 1'b0});
    issue(1'b0, 3'b111, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("rd_uart_psel", {30'd0, PSEL}, 32'd2);
      chk("rd_uart_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
      if (i == 4) begin
        @(posedge clk);
        #1 PREADY1 = 1'b1;
        PRDATA1 = 8'h3C;
      end
    end
    @(negedge clk);
    chk("rd_uart_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_uart_psel_drop", {30'd0, PSEL}, 32'd0);
    // GPIO read with PREADY0 stuck low must time out after 15 ACCESS cycles
    PREADY0 = 1'b0;
    exp_q.push_back({8'h00, 1'b1});
    issue(1'b0, 3'b001, 8'h00);
    acc = 0;
    cyc = 0;
    while (cyc < 40 && !rsp_valid) begin
      @(negedge clk);
      cyc++;
      if (PENABLE) acc++;
    end
    chk("to_rsp_cycle", cyc, 32'd17);
    chk("to_access_cycles", acc, 32'd15);
    chk("to_psel_in_rsp", {30'd0, PSEL}, 32'd0);
    // back-to-back writes with req_valid held high
    PREADY0 = 1'b1;
    exp_q.push_back({8'h00, 1'b0});
    exp_q.push_back({8'h00, 1'b0});
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 3'b000;
    req_wdata = 8'h11;
    @(posedge clk);
    #1 req_wdata = 8'h22;
    @(negedge clk);
    chk("b2b_setup1_pwdata", {24'd0, PWDATA}, 32'h11);
    chk("b2b_setup1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_access1_pwdata", {24'd0, PWDATA}, 32'h11);
    @(negedge clk);
    chk("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp1_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_gap_psel", {30'd0, PSEL}, 32'd0);
    chk("b2b_gap_pwdata", {24'd0, PWDATA}, 32'h11);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_setup2_psel", {30'd0, PSEL}, 32'd1);
    chk("b2b_setup2_pwdata", {24'd0, PWDATA}, 32'h22);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
    // reset during ACCESS with PREADY low drops the transfer
    PREADY0 = 1'b0;
    issue(1'b0, 3'b011, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_access", {31'd0, PENABLE}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    PREADY0 = 1'b1;
    PRDATA0 = 8'h5A;
    exp_q.push_back({8'h5A, 1'b0});
    issue(1'b0, 3'b001, 8'h00);
    cyc = 0;
    while (cyc < 10 && !rsp_valid) begin
      @(negedge clk);
      cyc++;
    end
    chk("fresh_rd_latency", cyc, 32'd3);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_bus_master.md
# apb_bus_master

Single-initiator APB bridge that turns simple request/response transactions from the system controller into APB SETUP/ACCESS transfers toward the GPIO (slave 0) and UART (slave 1) peripherals. It generates per-slave select, enable, write strobe, 2-bit register select and 8-bit write data. It collects read data and PREADY from the addressed slave and returns a one-cycle response carrying data and an error flag. A timeout counter guarantees that a hung slave cannot lock the bus.

## Interface
- TIMEOUT, 15, maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  3  [2] slave index (0 GPIO, 1 UART), [1:0] register select
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  8  read data; 0 for writes and errors
- rsp_err  out  1  valid with rsp_valid; 1 = timeout
- PSEL  out  2  one-hot slave select
- PENABLE  out  1  ACCESS phase indicator
- PWRITE  out  1  transfer direction
- PADDR  out  2  register select to slaves (REGSEL)
- PWDATA  out  8  write data to slaves
- PRDATA0 / PRDATA1  in  8  read data from GPIO / UART
- PREADY0 / PREADY1  in  1  transfer-complete from GPIO / UART

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready = 1 (combinational from state).
  - PSEL = 0, PENABLE = 0.
  - On accept: latch req_write into PWRITE, req_addr[1:0] into PADDR, req_wdata into PWDATA and the slave index; go to SETUP.
- SETUP:
  - PSEL[idx] = 1, PENABLE = 0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - PSEL[idx] = 1, PENABLE = 1.
  - Only the selected slave's PREADY/PRDATA is observed; the other slave's inputs are ignored.
  - PREADY high: on that edge capture PRDATA (reads) or 0 (writes) into rsp_rdata, set rsp_err = 0, go to IDLE.
  - PREADY low: increment the wait counter. When the counter reaches TIMEOUT (TIMEOUT ≠ 0), abort: rsp_rdata = 0, rsp_err = 1, go to IDLE.
- rsp_valid:
  - Registered; high for exactly the one cycle after completion or abort.
  - rsp_rdata and rsp_err hold their values until the next response.
- PWRITE, PADDR and PWDATA are stable from SETUP through the end of ACCESS, then hold their last value in IDLE.
- Wait counter clears on entry to SETUP. Width is ceil(log2(TIMEOUT+1)), minimum 1 bit.

## Timing
- Reset (rst_n low at a rising edge): state = IDLE, and PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. req_ready = 0 while rst_n is low, 1 in the first cycle after release.
- Request accepted at edge T:
  - SETUP during cycle T+1.
  - ACCESS from cycle T+2.
  - Zero-wait completion at edge T+3; rsp_valid high in cycle T+3.
- N PREADY-low cycles add N cycles of latency.
- Timeout: abort at the edge ending the TIMEOUT-th PREADY-low ACCESS cycle; PSEL/PENABLE drop in the next cycle.
- Back-to-back: a new request may be accepted in the same cycle that rsp_valid is high. Peak throughput is one transfer per 3 cycles; PSEL drops for at least one cycle between transfers.
- Reset asserted mid-SETUP or mid-ACCESS: transfer dropped at that edge, no response issued, all outputs take reset values.

## Test plan
- After reset release, write 8'hA5 to GPIO reg 2'b10 with PREADY0 tied high:
  - T+1: PSEL = 2'b01, PENABLE = 0, PWRITE = 1, PADDR = 2'b10, PWDATA = 8'hA5.
  - T+2: PENABLE = 1.
  - T+3: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Read UART reg 2'b11, PREADY1 low 3 ACCESS cycles then high with PRDATA1 = 8'h3C:
  - PSEL = 2'b10 for 5 cycles.
  - rsp_rdata = 8'h3C, rsp_err = 0 at T+6.
  - PRDATA0 = 8'hFF during the transfer is ignored.
- TIMEOUT = 15, GPIO read with PREADY0 stuck low:
  - abort after 15 ACCESS cycles.
  - rsp_err = 1, rsp_rdata = 0, PSEL = 0 in the response cycle.
- Back-to-back writes with req_valid held high:
  - second accept coincides with first rsp_valid.
  - PSEL low exactly one cycle between transfers.
  - PWDATA switches only at the second SETUP.
- rst_n driven low during ACCESS with PREADY low:
  - next cycle all outputs at reset values, no rsp_valid.
  - after release, req_ready = 1 and a fresh read completes normally.
